// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Define MULT_DIV_UNIT_DIV_EN to build the divider; otherwise DIV/DIVU are ignored like ops 6/7.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MULT_DIV_UNIT_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_FIX  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mag_a;
    logic             neg_a, neg_b;
    // Multiply: {partial sum, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] prod;

    logic             signed_op;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod_fix;

    assign signed_op = (i_op == 3'd0) || (i_op == 3'd2);
    assign abs_a     = (signed_op && i_a[WIDTH-1]) ? -i_a : i_a;
    assign abs_b     = (signed_op && i_b[WIDTH-1]) ? -i_b : i_b;
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mag_a : {WIDTH{1'b0}})};
    assign mul_next  = {mul_sum, prod[WIDTH-1:1]};
    assign prod_fix  = (neg_a ^ neg_b) ? -prod : prod;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic [WIDTH-1:0] mag_b, a_raw, quo_fix, rem_fix;
    logic             is_div;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_ge    = !div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        prod[WIDTH-2:0], div_ge};
    assign quo_fix   = (neg_a ^ neg_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign rem_fix   = neg_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_hi   <= '0;
            o_lo   <= '0;
            mag_a  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            prod   <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
            mag_b  <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        case (i_op)
                            3'd0, 3'd1: begin
                                state  <= S_MUL;
                                o_busy <= 1'b1;
                                cnt    <= '0;
                                mag_a  <= abs_a;
                                prod   <= {{WIDTH{1'b0}}, abs_b};
                                neg_a  <= signed_op && i_a[WIDTH-1];
                                neg_b  <= signed_op && i_b[WIDTH-1];
`ifdef MULT_DIV_UNIT_DIV_EN
                                is_div <= 1'b0;
`endif
                            end
`ifdef MULT_DIV_UNIT_DIV_EN
                            3'd2, 3'd3: begin
                                state  <= S_DIV;
                                o_busy <= 1'b1;
                                cnt    <= '0;
                                mag_b  <= abs_b;
                                a_raw  <= i_a;
                                prod   <= {{WIDTH{1'b0}}, abs_a};
                                neg_a  <= signed_op && i_a[WIDTH-1];
                                neg_b  <= signed_op && i_b[WIDTH-1];
                                is_div <= 1'b1;
                            end
`endif
                            3'd4: begin
                                o_hi   <= i_a;
                                o_done <= 1'b1;
                            end
                            3'd5: begin
                                o_lo   <= i_a;
                                o_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
`ifdef MULT_DIV_UNIT_DIV_EN
                S_DIV: begin
                    prod <= div_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
`endif
                S_FIX: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    cnt    <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
                    if (is_div) begin
                        // Zero divisor bypasses the sign fix-up: LO all ones, HI the raw dividend.
                        if (mag_b == '0) begin
                            o_lo <= '1;
                            o_hi <= a_raw;
                        end else begin
                            o_lo <= quo_fix;
                            o_hi <= rem_fix;
                        end
                    end else begin
                        o_hi <= prod_fix[2*WIDTH-1:WIDTH];
                        o_lo <= prod_fix[WIDTH-1:0];
                    end
`else
                    o_hi <= prod_fix[2*WIDTH-1:WIDTH];
                    o_lo <= prod_fix[WIDTH-1:0];
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random bench for mult_div_unit against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

`ifdef MULT_DIV_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    mult_div_unit #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO become for a request issued from idle.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output bit iter, output bit move,
                                  output logic [31:0] nh, output logic [31:0] nl);
        logic signed [63:0] sp;
        logic [63:0] up;
        logic signed [31:0] sx, sy;
        nh = m_hi; nl = m_lo; iter = 0; move = 0;
        sx = x; sy = y;
        case (o)
            3'd0: begin
                sp = 64'(sx) * 64'(sy);
                {nh, nl} = sp; iter = 1;
            end
            3'd1: begin
                up = {32'h0, x} * {32'h0, y};
                {nh, nl} = up; iter = 1;
            end
            3'd2, 3'd3: if (DIV_EN) begin
                iter = 1;
                if (y == 0) begin
                    nl = 32'hFFFF_FFFF; nh = x;
                end else if (o == 3'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    nl = 32'h8000_0000; nh = 0;
                end else if (o == 3'd2) begin
                    nl = sx / sy; nh = sx % sy;
                end else begin
                    nl = x / y; nh = x % y;
                end
            end
            3'd4: begin nh = x; move = 1; end
            3'd5: begin nl = x; move = 1; end
            default: ;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit iter, move, held;
        logic [31:0] nh, nl;
        int n;
        model(o, x, y, iter, move, nh, nl);
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 0; a = $urandom; b = $urandom;
        if (iter) begin
            check("busy_after_start", busy, 1);
            check("no_done_at_start", done, 0);
            n = 0; held = 1;
            while (busy && n < 100) begin
                if (hi !== m_hi || lo !== m_lo) held = 0;
                @(posedge clk); #1;
                n++;
            end
            check("hilo_held_while_busy", held, 1);
            check("busy_cycles", n, 33);
            check("done_pulse", done, 1);
        end else begin
            check("busy_stays_low", busy, 0);
            check("done_move_or_ignore", done, move);
        end
        check("hi", hi, nh);
        check("lo", lo, nl);
        m_hi = nh; m_lo = nl;
    endtask

    initial begin
        bit saw_done, held;
        int n;
        logic [31:0] nh, nl;
        bit iter, move;
        rst = 1; start = 0; op = 0; a = 0; b = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        @(negedge clk); rst = 0;

        do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg3x7_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg3x7_lo", lo, 32'hFFFF_FFEB);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd3, 32'd100, 32'd0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd0);
        do_op(3'd6, 32'h1, 32'h2);
        do_op(3'd7, 32'h3, 32'h4);
        // Back-to-back moves
        do_op(3'd5, 32'hCAFE_0001, 32'h0);
        do_op(3'd4, 32'h1234_5678, 32'h0);
        check("mthi_value", hi, 32'h1234_5678);

        // MULT 2x3 with an MTLO attempt while busy: must be dropped
        model(3'd0, 32'd2, 32'd3, iter, move, nh, nl);
        @(negedge clk); start = 1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        start = 1; op = 3'd5; a = 32'hDEAD_BEEF;
        @(negedge clk); start = 0;
        check("busy_mtlo_ignored_lo", lo, m_lo);
        check("busy_hi_held", hi, 32'h1234_5678);
        n = 0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check("mult_2x3_done", done, 1);
        check("mult_2x3_hi", hi, 32'h0);
        check("mult_2x3_lo", lo, 32'h6);
        m_hi = nh; m_lo = nl;

        for (int i = 0; i < 24; i++) begin
            logic [2:0] ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'h0 : ((i % 7 == 3) ? 32'($urandom_range(1, 9)) : $urandom);
            if (i % 6 == 2) ra = 32'h8000_0000;
            do_op(ro, ra, rb);
        end

        // Reset in the middle of a long operation
        @(negedge clk); start = 1; op = DIV_EN ? 3'd3 : 3'd1; a = 32'd1000; b = 32'd7;
        @(negedge clk); start = 0;
        repeat (9) @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        @(negedge clk); rst = 0;
        saw_done = 0; held = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
            if (busy) held = 0;
        end
        check("rst_no_done", saw_done, 0);
        check("rst_stays_idle", held, 1);
        m_hi = 0; m_lo = 0;
        do_op(3'd0, 32'h7FFF_FFFF, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with HI/LO result registers, fed directly by the register file's two read ports (`o_data1` to `i_a`, `o_data2` to `i_b`). It executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles using shift-add and restoring division, and MTHI/MTLO in one cycle. It exposes HI/LO to the pipeline for MFHI/MFLO, and a busy/done handshake so the hazard logic can stall on access to HI/LO.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width.

- `i_clk`  in  1  clock; every register updates on its rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  request; sampled only while `o_busy`=0.
- `i_op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Codes 6 and 7 are ignored.
- `i_a`  in  WIDTH  signed; multiplicand, dividend, or MTHI/MTLO source.
- `i_b`  in  WIDTH  signed; multiplier or divisor.
- `o_busy`  out  1  iterative operation in progress.
- `o_done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `o_hi`  out  WIDTH  HI register.
- `o_lo`  out  WIDTH  LO register.

## Operation
- **States:** IDLE, MUL, DIV, FIX.
  - IDLE to MUL on start with op 0 or 1.
  - IDLE to DIV on start with op 2 or 3.
  - MUL or DIV to FIX after WIDTH iterations.
  - FIX to IDLE unconditionally.
- **Operand capture:** operands are latched at start. Signed ops convert both operands to magnitudes and record the sign flags. The inputs are don't-care afterwards.
- **MUL:** one shift-add step per cycle on a 2×WIDTH accumulator.
- **DIV:** one restoring step per cycle; produces quotient and remainder.
- **FIX:** applies signs, then writes the results.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MULT/MULTU write HI = product[2W-1:W] and LO = product[W-1:0].
  - DIV/DIVU write LO = quotient and HI = remainder.
- **Divide by zero:** LO = all ones and HI = `i_a`, for both signed and unsigned.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000 and HI = 0 (two's-complement wrap).
- **MTHI/MTLO:** accepted in IDLE. At the sampling edge, HI (or LO) is written with `i_a`; the other register is unchanged. `o_busy` stays 0.
- **HI/LO hold:** HI/LO keep their old values throughout MUL/DIV/FIX. Intermediate values are held in separate internal registers.
- **Ignored requests:** `i_start` while `o_busy`=1 is ignored, with no queuing. Opcodes 6 and 7 are ignored: no state change and no `o_done`.
- **Reset values:** state IDLE, `o_busy`=0, `o_done`=0, `o_hi`=0, `o_lo`=0, iteration counter 0.
- **Reset mid-operation:** aborts the operation. Outputs return to their reset values; no `o_done` is produced.

## Timing
- Start is accepted at edge E0 (`i_start`=1, `o_busy`=0, op 0–3).
- `o_busy`=1 from after E0 through after E(WIDTH). This is WIDTH+1 cycles, i.e. 33 for WIDTH=32.
- Edges E1 to E(WIDTH) perform the iterations. The FIX state is held in the cycle after E(WIDTH).
- At E(WIDTH+1): HI/LO are written, `o_busy`→0 and `o_done`→1.
- `o_done` lasts one cycle. A new start may be issued in that same cycle.
- MTHI/MTLO accepted at E0: register visible and `o_done`=1 after E0, for one cycle.
- Back-to-back MTHI/MTLO on consecutive cycles are all accepted.

## Configuration
- Macro: `MULT_DIV_UNIT_DIV_EN`.
- **Defined:** DIV/DIVU are supported as above.
- **Undefined:** DIV state and divider datapath are compiled out. Ops 2 and 3 are treated like ops 6 and 7: ignored, no busy, no done, HI/LO unchanged. MULT/MULTU/MTHI/MTLO are unaffected.

## Test plan
- **Signed multiply:** MULT `i_a`=0xFFFFFFFD (−3), `i_b`=7 → `o_busy` high 33 cycles, then `o_done` pulse with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **Unsigned multiply:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- **Signed divide:**
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** DIVU 100/0 → LO=0xFFFFFFFF, HI=0x00000064. With the macro undefined, the same stimulus → no busy, no done, HI/LO unchanged.
- **Move and hold:**
  - MTHI 0x12345678 → HI updated the next cycle with `o_done`, LO unchanged.
  - Then MULT 2×3 with `i_start` re-asserted at cycle 5 carrying MTLO → MTLO ignored, HI stays 0x12345678 until done, final HI=0, LO=6.
- **Reset mid-operation:** start DIVU, assert `i_rst` at cycle 10 → next cycle `o_busy`=0, HI=LO=0, no `o_done` within 40 cycles.
